// File: rtl/ahb_arbiter_mux.sv
// Two-master AHB-style arbiter with master-side address/control/write-data mux.
// Round-robin on ties, one-cycle grant pulse, overlapped re-arbitration in the data phase.
module ahb_arbiter_mux #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HBUSREQ_M0,
  input  logic                 HBUSREQ_M1,
  input  logic [ADDR_BITS-1:0] HADDR_M0,
  input  logic [ADDR_BITS-1:0] HADDR_M1,
  input  logic                 HWRITE_M0,
  input  logic                 HWRITE_M1,
  input  logic [DATA_BITS-1:0] HWDATA_M0,
  input  logic [DATA_BITS-1:0] HWDATA_M1,
  input  logic                 HREADY,
  output logic                 HGRANT_M0,
  output logic                 HGRANT_M1,
  output logic [ADDR_BITS-1:0] HADDR,
  output logic                 HWRITE,
  output logic [DATA_BITS-1:0] HWDATA,
  output logic [1:0]           HTRANS,
  output logic                 HMASTER
);

  typedef enum logic [1:0] {ARB, GRANT, ADDR, DATA} state_e;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_owner_q, last_owner_d;
  logic   other_req;

  // last_owner resets to 1 so master 0 wins the first tie.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ARB;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  // The owner's own request is ignored here: it must re-request from idle.
  assign other_req = owner_q ? HBUSREQ_M0 : HBUSREQ_M1;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ARB: begin
        if (HBUSREQ_M0 || HBUSREQ_M1) begin
          state_d = GRANT;
          if (HBUSREQ_M0 && HBUSREQ_M1) owner_d = ~last_owner_q;
          else                          owner_d = HBUSREQ_M1;
        end
      end
      GRANT: state_d = ADDR;
      ADDR: begin
        if (HREADY) state_d = DATA;
      end
      DATA: begin
        if (HREADY) begin
          last_owner_d = owner_q;
          if (other_req) begin
            state_d = GRANT;
            owner_d = ~owner_q;
          end else begin
            state_d = ARB;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    HGRANT_M0 = 1'b0;
    HGRANT_M1 = 1'b0;
    HADDR     = '0;
    HWRITE    = 1'b0;
    HWDATA    = '0;
    HTRANS    = TRANS_IDLE;
    HMASTER   = owner_q;
    case (state_q)
      GRANT: begin
        HGRANT_M0 = ~owner_q;
        HGRANT_M1 = owner_q;
      end
      ADDR: begin
        HADDR  = owner_q ? HADDR_M1  : HADDR_M0;
        HWRITE = owner_q ? HWRITE_M1 : HWRITE_M0;
        HTRANS = TRANS_NONSEQ;
      end
      DATA: HWDATA = owner_q ? HWDATA_M1 : HWDATA_M0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_arbiter_mux.sv
// Directed bench for ahb_arbiter_mux: reset/idle, single read, round-robin,
// wait states, request dropped in grant, asynchronous reset mid-transfer.
module tb_ahb_arbiter_mux;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] NSQ = 2'b10;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HBUSREQ_M0, HBUSREQ_M1;
  logic [31:0] HADDR_M0, HADDR_M1;
  logic        HWRITE_M0, HWRITE_M1;
  logic [31:0] HWDATA_M0, HWDATA_M1;
  logic        HREADY;
  logic        HGRANT_M0, HGRANT_M1;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [1:0]  HTRANS;
  logic        HMASTER;

  int vectors = 0;
  int miscompares = 0;

  ahb_arbiter_mux #(.ADDR_BITS(32), .DATA_BITS(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HBUSREQ_M0(HBUSREQ_M0), .HBUSREQ_M1(HBUSREQ_M1),
    .HADDR_M0(HADDR_M0), .HADDR_M1(HADDR_M1),
    .HWRITE_M0(HWRITE_M0), .HWRITE_M1(HWRITE_M1),
    .HWDATA_M0(HWDATA_M0), .HWDATA_M1(HWDATA_M1),
    .HREADY(HREADY),
    .HGRANT_M0(HGRANT_M0), .HGRANT_M1(HGRANT_M1),
    .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HTRANS(HTRANS), .HMASTER(HMASTER)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Control word packs {HGRANT_M0, HGRANT_M1, HTRANS, HMASTER, HWRITE}.
  task automatic chk_bus(input string tag, input logic g0, input logic g1, input logic [1:0] tr,
                         input logic mst, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    chk({tag, ".ctl"},   {58'd0, HGRANT_M0, HGRANT_M1, HTRANS, HMASTER, HWRITE},
                         {58'd0, g0, g1, tr, mst, wr});
    chk({tag, ".haddr"}, {32'd0, HADDR},  {32'd0, addr});
    chk({tag, ".hwdata"},{32'd0, HWDATA}, {32'd0, wdata});
  endtask

  initial begin
    logic m;
    HRESETn    = 1'b1;
    HBUSREQ_M0 = 1'b0; HBUSREQ_M1 = 1'b0;
    HADDR_M0   = '0;   HADDR_M1   = '0;
    HWRITE_M0  = 1'b0; HWRITE_M1  = 1'b0;
    HWDATA_M0  = '0;   HWDATA_M1  = '0;
    HREADY     = 1'b1;
    #2 HRESETn = 1'b0;

    // Reset then idle
    repeat (3) tick();
    chk_bus("in_reset", 0, 0, IDL, 0, 0, 32'h0, 32'h0);
    HRESETn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_bus($sformatf("idle%0d", i), 0, 0, IDL, 0, 0, 32'h0, 32'h0);
    end

    // Single read, master 0
    HBUSREQ_M0 = 1'b1; HADDR_M0 = 32'h0000_0040; HWDATA_M0 = 32'h1111_1111;
    tick();
    chk_bus("rd0.grant", 1, 0, IDL, 0, 0, 32'h0, 32'h0);
    HBUSREQ_M0 = 1'b0;
    tick();
    chk_bus("rd0.addr", 0, 0, NSQ, 0, 0, 32'h40, 32'h0);
    tick();
    chk_bus("rd0.data", 0, 0, IDL, 0, 0, 32'h0, 32'h1111_1111);
    tick();
    chk_bus("rd0.arb", 0, 0, IDL, 0, 0, 32'h0, 32'h0);

    // Simultaneous requests from reset: M0, M1, M0, M1 every 3 cycles
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    HADDR_M0 = 32'h100; HADDR_M1 = 32'h200;
    HWRITE_M0 = 1'b0;   HWRITE_M1 = 1'b1;
    HWDATA_M0 = 32'hAAAA_0000; HWDATA_M1 = 32'hBBBB_0001;
    HBUSREQ_M0 = 1'b1; HBUSREQ_M1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m = k[0];
      tick();
      chk_bus($sformatf("rr%0d.grant", k), ~m, m, IDL, m, 0, 32'h0, 32'h0);
      if (k == 3) begin
        HBUSREQ_M0 = 1'b0; HBUSREQ_M1 = 1'b0;
      end
      tick();
      chk_bus($sformatf("rr%0d.addr", k), 0, 0, NSQ, m, m, m ? 32'h200 : 32'h100, 32'h0);
      tick();
      chk_bus($sformatf("rr%0d.data", k), 0, 0, IDL, m, 0, 32'h0,
              m ? 32'hBBBB_0001 : 32'hAAAA_0000);
    end
    tick();
    chk_bus("rr.arb", 0, 0, IDL, 1, 0, 32'h0, 32'h0);

    // Wait states on a master 1 write: 2 low cycles in ADDR, 3 in DATA
    HBUSREQ_M1 = 1'b1; HADDR_M1 = 32'h8000_0004; HWDATA_M1 = 32'hDEAD_BEEF;
    tick();
    chk_bus("ws.grant", 0, 1, IDL, 1, 0, 32'h0, 32'h0);
    HBUSREQ_M1 = 1'b0; HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bus($sformatf("ws.addr%0d", i), 0, 0, NSQ, 1, 1, 32'h8000_0004, 32'h0);
    end
    HREADY = 1'b1;
    tick();
    HREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      if (i == 3) HREADY = 1'b1;
      chk_bus($sformatf("ws.data%0d", i), 0, 0, IDL, 1, 0, 32'h0, 32'hDEAD_BEEF);
    end
    tick();
    chk_bus("ws.arb", 0, 0, IDL, 1, 0, 32'h0, 32'h0);

    // Request dropped in GRANT: M0 still completes, then M1 is granted straight from DATA
    HBUSREQ_M0 = 1'b1; HADDR_M0 = 32'h0000_0123; HWDATA_M0 = 32'h5A5A_5A5A;
    tick();
    chk_bus("drop.grant", 1, 0, IDL, 0, 0, 32'h0, 32'h0);
    HBUSREQ_M0 = 1'b0;
    tick();
    chk_bus("drop.addr", 0, 0, NSQ, 0, 0, 32'h123, 32'h0);
    HBUSREQ_M1 = 1'b1;
    tick();
    chk_bus("drop.data", 0, 0, IDL, 0, 0, 32'h0, 32'h5A5A_5A5A);
    tick();
    chk_bus("drop.grant_m1", 0, 1, IDL, 1, 0, 32'h0, 32'h0);
    HBUSREQ_M1 = 1'b0;
    tick();
    tick();
    tick();
    chk_bus("drop.arb", 0, 0, IDL, 1, 0, 32'h0, 32'h0);

    // Asynchronous reset in DATA with HREADY low
    HBUSREQ_M1 = 1'b1; HWDATA_M1 = 32'hCAFE_F00D;
    tick();
    HBUSREQ_M1 = 1'b0;
    tick();
    tick();
    HREADY = 1'b0;
    chk_bus("ar.data", 0, 0, IDL, 1, 0, 32'h0, 32'hCAFE_F00D);
    tick();
    chk_bus("ar.data_hold", 0, 0, IDL, 1, 0, 32'h0, 32'hCAFE_F00D);
    #2 HRESETn = 1'b0;
    #1;
    chk_bus("ar.async", 0, 0, IDL, 0, 0, 32'h0, 32'h0);
    tick();
    HRESETn = 1'b1; HREADY = 1'b1;
    HBUSREQ_M0 = 1'b1; HBUSREQ_M1 = 1'b1;
    tick();
    chk_bus("ar.tie_grant", 1, 0, IDL, 0, 0, 32'h0, 32'h0);
    HBUSREQ_M0 = 1'b0; HBUSREQ_M1 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
